// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin access to a shared bank of SR flag bits.
// One command per two cycles; S=R=1 and out-of-range indices are rejected.
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IW    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    s,
    input  logic [NREQ-1:0]    r,
    input  logic [NREQ*IW-1:0] idx,
    input  logic               clr_all,
    output logic [NREQ-1:0]    gnt,
    output logic [NFLAG-1:0]   flags,
    output logic               err,
    output logic [2:0]         err_id,
    output logic               busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state;
    logic [2:0]     ptr;
    logic [2:0]     win_q;
    logic           s_q;
    logic           r_q;
    logic [IW-1:0]  idx_q;

    logic           found;
    logic [2:0]     win;
    logic           win_s;
    logic           win_r;
    logic [IW-1:0]  win_idx;
    int             best;
    logic           cmd_bad;
    logic           cmd_apply;

    // Rotating priority search: the nearest requester after ptr wins.
    always_comb begin
        found   = |req;
        win     = ptr;
        win_s   = 1'b0;
        win_r   = 1'b0;
        win_idx = '0;
        best    = NREQ;
        for (int j = 0; j < NREQ; j++) begin
            if (req[j] &&
                ((j - int'(ptr) - 1 + 2 * NREQ) % NREQ) < best) begin
                best    = (j - int'(ptr) - 1 + 2 * NREQ) % NREQ;
                win     = 3'(j);
                win_s   = s[j];
                win_r   = r[j];
                win_idx = idx[j*IW +: IW];
            end
        end
    end

    // Classify the latched command; range check uses all IW index bits.
    always_comb begin
        cmd_bad   = (s_q & r_q) | (int'(idx_q) >= NFLAG);
        cmd_apply = (state == GRANT) & ~cmd_bad & (s_q ^ r_q);
    end

    // Two-state sequencer: arbitrate and latch in IDLE, retire in GRANT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            gnt    <= '0;
            busy   <= 1'b0;
            err    <= 1'b0;
            err_id <= '0;
            ptr    <= 3'(NREQ - 1);
            win_q  <= '0;
            s_q    <= 1'b0;
            r_q    <= 1'b0;
            idx_q  <= '0;
        end else begin
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        gnt   <= NREQ'(1) << win;
                        busy  <= 1'b1;
                        ptr   <= win;
                        win_q <= win;
                        s_q   <= win_s;
                        r_q   <= win_r;
                        idx_q <= win_idx;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (cmd_bad) begin
                        err    <= 1'b1;
                        err_id <= win_q;
                    end
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Flag bank: clr_all overrides any update landing on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= '0;
        end else if (clr_all) begin
            flags <= '0;
        end else if (cmd_apply) begin
            for (int f = 0; f < NFLAG; f++) begin
                if (idx_q == IW'(f)) begin
                    flags[f] <= s_q;
                end
            end
        end
    end

endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one bank of NFLAG set/reset flag bits among NREQ requesters.
- Each requester presents a set/reset command pair and a flag index. The block grants one requester at a time, applies the SR command to the addressed flag, and acknowledges with a one-cycle grant.
- The S=R=1 command has a defined outcome: it is rejected, the flag is unchanged, and an error is flagged. The flag bank never goes to an undefined or high-impedance value.
- Sits between control agents and the shared status-flag register used by downstream logic.

Parameters:
- NREQ, 4, number of requesters (2..8)
- NFLAG, 8, number of SR flag bits in the bank
- IW, 3, flag index width; IW >= clog2(NFLAG)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester request; held high until the matching gnt is seen
- s  input  NREQ  per-requester set command bit
- r  input  NREQ  per-requester reset command bit
- idx  input  NREQ*IW  per-requester flag index; requester k uses bits [k*IW +: IW]
- clr_all  input  1  synchronous clear of the entire flag bank
- gnt  output  NREQ  one-hot, one-cycle grant/acknowledge
- flags  output  NFLAG  flag bank contents
- err  output  1  one-cycle pulse for a rejected command
- err_id  output  3  requester number of the last rejected command
- busy  output  1  high while state is GRANT

Behaviour:
- Reset (reset=0, asynchronous, effective immediately, including mid-transaction):
  - state=IDLE
  - gnt=0, flags=0, err=0, err_id=0, busy=0
  - rr pointer = NREQ-1, so requester 0 has first priority
  - any in-flight command is discarded
- FSM has two states, IDLE and GRANT, and runs one transaction per 2 cycles.
- IDLE, at a clock edge with req != 0:
  - Winner = first requester with req high, searching from (ptr+1) mod NREQ upward with wrap.
  - Latch the winner's s, r and idx.
  - Set gnt[winner]=1 and busy=1; all other gnt bits stay 0.
  - ptr <= winner; state <= GRANT.
- IDLE with req == 0: remain in IDLE; all outputs hold.
- GRANT, at the next edge, using the latched command:
  - s=1, r=0: flags[idx] <= 1
  - s=0, r=1: flags[idx] <= 0
  - s=0, r=0: no change (legal no-op, still acknowledged)
  - s=1, r=1: no change; err <= 1; err_id <= winner
  - idx >= NFLAG: no change; err <= 1; err_id <= winner
  - Then gnt <= 0, busy <= 0, state <= IDLE.
- Latency and visibility:
  - gnt is high for exactly the one cycle between the arbitration edge and the update edge.
  - The updated flag and any err pulse become visible together in the cycle after gnt.
  - err is high for exactly one cycle per rejected command.
- Request handshake:
  - req, s, r and idx are sampled only at the arbitration edge; changes at any other time are ignored.
  - A requester drops req at the edge that ends its gnt cycle. If req is still high in the next IDLE cycle, it is a new request and competes normally; the rr pointer has moved past it.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,NREQ-1,0,…, so each requester is serviced at most 2*NREQ cycles after it asserts req.
- clr_all:
  - At any edge, all flags <= 0.
  - If it coincides with a GRANT update, clr_all wins: the update is discarded, but gnt still completes and err still fires for an illegal command.
  - Has no effect on the FSM or the rr pointer.
- Width rules: ptr and winner are 3 bits, compared mod NREQ. Index range checking uses the full IW bits.

Test Plan:
- Reset released, req=0001, s[0]=1, r[0]=0, idx0=5 -> gnt=0001 for one cycle, 1 cycle after the edge; next cycle flags=0010_0000, err=0.
- req=1111 held with legal commands -> grant order 0,1,2,3,0 on every second cycle; busy toggles 1,0.
- Requester 2 issues s=1, r=1 at idx=3 with flags[3]=1 -> gnt[2] pulses; flags[3] stays 1; err pulses one cycle; err_id=2.
- flags=0xFF; requester 1 sends clear idx=4 and clr_all asserts on the update edge -> flags=0x00; gnt[1] was asserted; err=0.
- reset asserted during GRANT with gnt=0100 -> gnt=0, flags=0 and state IDLE immediately, without a clock edge; after release, requester 0 wins first.
- NFLAG=6, IW=3: requester 3 sends idx=7, s=1 -> flags unchanged; err=1; err_id=3.
